// File: rtl/sram_ctrl_ws.sv
// Wait-state bridge from the core memory stage to 16-bit async SRAM; SRAM_CTRL_BYTE_EN adds store byte enables.
// Latency: request in cycle k -> ready in cycle k+1+BEATS*(WAIT_STATES+1).
// Backpressure: ready stays low while a request is pending; the pipeline holds rd_en/wr_en until ready.
module sram_ctrl_ws #(
  parameter int CPU_DW      = 32,
  parameter int SRAM_DW     = 16,
  parameter int SRAM_AW     = 18,
  parameter int WAIT_STATES = 2,
  parameter int ADDR_BASE   = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        addr,
  input  logic [CPU_DW-1:0]  wdata,
`ifdef SRAM_CTRL_BYTE_EN
  input  logic [CPU_DW/8-1:0] be,
`endif
  output logic [CPU_DW-1:0]  rdata,
  output logic               ready,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_WE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N
);

  localparam int BEATS = CPU_DW / SRAM_DW;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WSH   = $clog2(CPU_DW / 8);
  localparam int BPB   = SRAM_DW / 8;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state, state_nxt;
  logic                op_wr;
  logic [31:0]         addr_q;
  logic [31:0]         addr_word;
  logic [CPU_DW-1:0]   wdata_q;
  logic [CPU_DW-1:0]   rd_buf, rd_nxt;
  logic [BW-1:0]       beat;
  logic [3:0]          cnt;
  logic                req, beat_end, last_beat;
  logic                dq_oe;
  logic [SRAM_DW-1:0]  beat_wdat;
`ifdef SRAM_CTRL_BYTE_EN
  logic [CPU_DW/8-1:0] be_q;
`endif

  assign req       = rd_en | wr_en;
  assign beat_end  = (cnt == 4'(WAIT_STATES));
  assign last_beat = (beat == BW'(BEATS - 1));
  assign beat_wdat = wdata_q[int'(beat)*SRAM_DW +: SRAM_DW];
  assign SRAM_DQ   = dq_oe ? beat_wdat : {SRAM_DW{1'bz}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Strobes decode straight from registered state so an async reset releases the bus at once.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    SRAM_CE_N = 1'b1;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_UB_N = 1'b1;
    SRAM_LB_N = 1'b1;
    dq_oe     = 1'b0;
    case (state)
      IDLE: begin
        ready = ~req;
        if (req) state_nxt = ACCESS;
      end
      ACCESS: begin
        SRAM_CE_N = 1'b0;
        SRAM_UB_N = 1'b0;
        SRAM_LB_N = 1'b0;
        if (op_wr) begin
`ifdef SRAM_CTRL_BYTE_EN
          SRAM_LB_N = ~be_q[int'(beat)*BPB];
          SRAM_UB_N = ~be_q[int'(beat)*BPB + BPB - 1];
          SRAM_WE_N = SRAM_UB_N & SRAM_LB_N;
          dq_oe     = ~SRAM_WE_N;
`else
          SRAM_WE_N = 1'b0;
          dq_oe     = 1'b1;
`endif
        end else begin
          SRAM_OE_N = 1'b0;
        end
        if (beat_end && last_beat) state_nxt = DONE;
      end
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    addr_word = (addr_q - 32'(ADDR_BASE)) >> WSH;
    SRAM_ADDR = '0;
    if (state == ACCESS)
      SRAM_ADDR = SRAM_AW'(addr_word * 32'(BEATS) + 32'(beat));
  end

  // Read beats assemble in rd_buf; rdata only changes when the whole load lands.
  always_comb begin
    rd_nxt = rd_buf;
    rd_nxt[int'(beat)*SRAM_DW +: SRAM_DW] = SRAM_DQ;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_wr   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      beat    <= '0;
      cnt     <= '0;
      rd_buf  <= '0;
      rdata   <= '0;
`ifdef SRAM_CTRL_BYTE_EN
      be_q    <= '0;
`endif
    end else if (state == IDLE) begin
      if (req) begin
        op_wr   <= wr_en;
        addr_q  <= addr;
        wdata_q <= wdata;
        beat    <= '0;
        cnt     <= '0;
`ifdef SRAM_CTRL_BYTE_EN
        be_q    <= be;
`endif
      end
    end else if (state == ACCESS) begin
      if (beat_end) begin
        cnt <= '0;
        if (!op_wr) begin
          if (last_beat) rdata  <= rd_nxt;
          else           rd_buf <= rd_nxt;
        end
        beat <= last_beat ? '0 : beat + 1'b1;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_sram_ctrl_ws.sv
// Directed bench for sram_ctrl_ws (default parameters) with a behavioural async SRAM and a read scoreboard.
module tb_sram_ctrl_ws;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        ub_n, lb_n, we_n, ce_n, oe_n;
`ifdef SRAM_CTRL_BYTE_EN
  logic [3:0]  be;
`endif

  logic        mem_clr = 1'b1;
  logic        probe_en;
  logic [15:0] mem    [0:255];
  int          we_cnt [0:255];
  logic [15:0] shadow [0:255];
  logic [31:0] exp_q  [$];
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  sram_ctrl_ws dut (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .addr      (addr),
    .wdata     (wdata),
`ifdef SRAM_CTRL_BYTE_EN
    .be        (be),
`endif
    .rdata     (rdata),
    .ready     (ready),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_UB_N (ub_n),
    .SRAM_LB_N (lb_n),
    .SRAM_WE_N (we_n),
    .SRAM_CE_N (ce_n),
    .SRAM_OE_N (oe_n)
  );

  // Async SRAM: drives on CE&OE&!WE, stores per byte lane while CE&WE are low.
  wire [7:0] ma = sram_addr[7:0];
  assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[ma] : 16'hzzzz;
  assign sram_dq = probe_en ? 16'h5A5A : 16'hzzzz;

  always @(negedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) begin
        mem[i]    <= 16'hA000 + 16'(i);
        we_cnt[i] <= 0;
      end
    end else if (!ce_n && !we_n) begin
      if (!lb_n) mem[ma][7:0]  <= sram_dq[7:0];
      if (!ub_n) mem[ma][15:8] <= sram_dq[15:8];
      we_cnt[ma] <= we_cnt[ma] + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_access(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be_v, input bit perturb, input string tag);
    logic [31:0] w;
    logic [17:0] s0;
    logic [7:0]  i0, i1;
    int          lat;
    w  = (a - 32'd1024) >> 2;
    s0 = 18'(w * 32'd2);
    i0 = s0[7:0];
    i1 = i0 + 8'd1;
    @(posedge clk); #1;
    rd_en = rd; wr_en = wr; addr = a; wdata = wd;
`ifdef SRAM_CTRL_BYTE_EN
    be = be_v;
`endif
    if (wr) begin
`ifdef SRAM_CTRL_BYTE_EN
      if (be_v[0]) shadow[i0][7:0]  = wd[7:0];
      if (be_v[1]) shadow[i0][15:8] = wd[15:8];
      if (be_v[2]) shadow[i1][7:0]  = wd[23:16];
      if (be_v[3]) shadow[i1][15:8] = wd[31:24];
`else
      shadow[i0] = wd[15:0];
      shadow[i1] = wd[31:16];
`endif
    end else begin
      exp_q.push_back({shadow[i1], shadow[i0]});
    end
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 1) chk({tag, "_addr0"}, sram_addr, s0);
      if (i == 4) chk({tag, "_addr1"}, sram_addr, s0 + 18'd1);
      if (ready) begin
        lat = i;
        break;
      end
      if (perturb && i == 2) begin
        rd_en = 1'b0; addr = 32'h0; wdata = ~wd;
      end
    end
    chk({tag, "_latency"}, lat, 7);
    if (wr) begin
      chk({tag, "_mem_lo"}, mem[i0], shadow[i0]);
      chk({tag, "_mem_hi"}, mem[i1], shadow[i1]);
    end else begin
      chk({tag, "_sb_size"}, exp_q.size(), 1);
      if (exp_q.size() > 0) chk({tag, "_rdata"}, rdata, exp_q.pop_front());
    end
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    int lat;
    int c0;
    rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0; probe_en = 1'b0;
`ifdef SRAM_CTRL_BYTE_EN
    be = 4'hF;
`endif
    for (int i = 0; i < 256; i++) shadow[i] = 16'hA000 + 16'(i);
    @(negedge clk); @(negedge clk); #1;
    mem_clr = 1'b0;

    // Reset held with a load pending
    rd_en = 1'b1; addr = 32'd1024;
    @(negedge clk);
    chk("rst_strobes", {ce_n, we_n, oe_n, ub_n, lb_n}, 5'h1F);
    chk("rst_addr", sram_addr, 18'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ready", ready, 1'b0);
    probe_en = 1'b1; #1;
    chk("rst_dq_hiz", sram_dq, 16'h5A5A);
    probe_en = 1'b0;
    exp_q.push_back({shadow[1], shadow[0]});
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rel_started", {ce_n, oe_n}, 2'b00);
    lat = -1;
    for (int i = 2; i < 40; i++) begin
      @(negedge clk);
      if (ready) begin
        lat = i;
        break;
      end
    end
    chk("rel_latency", lat, 7);
    chk("rel_sb_size", exp_q.size(), 1);
    if (exp_q.size() > 0) chk("rel_rdata", rdata, exp_q.pop_front());
    @(posedge clk); #1 rd_en = 1'b0;

    do_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 4'hF, 1'b0, "wr1024");
    chk("wr1024_lo_const", mem[0], 16'hBEEF);
    chk("wr1024_hi_const", mem[1], 16'hDEAD);
    do_access(1'b0, 1'b1, 32'd1024, 32'h0, 4'hF, 1'b0, "rd1024");

    do_access(1'b1, 1'b0, 32'd1032, 32'hCAFEF00D, 4'hF, 1'b0, "wr1032");
    chk("wr1032_we_cycles4", we_cnt[4], 3);
    chk("wr1032_we_cycles5", we_cnt[5], 3);

    // Both requests (store wins), load dropped and addr/wdata scrambled mid-access
    do_access(1'b1, 1'b1, 32'd1028, 32'h12345678, 4'hF, 1'b1, "both1028");
    chk("both1028_lo_const", mem[2], 16'h5678);
    chk("both1028_hi_const", mem[3], 16'h1234);
    chk("rdata_hold", rdata, 32'hDEADBEEF);
    do_access(1'b0, 1'b1, 32'd1028, 32'h0, 4'hF, 1'b0, "rd1028");

    // Below ADDR_BASE wraps to the top of SRAM
    do_access(1'b1, 1'b0, 32'd1020, 32'h5A5AA5A5, 4'hF, 1'b0, "wr_wrap");
    do_access(1'b0, 1'b1, 32'd1020, 32'h0, 4'hF, 1'b0, "rd_wrap");

    // Reset in the third cycle of a store
    @(posedge clk); #1;
    wr_en = 1'b1; addr = 32'd1040; wdata = 32'h11112222;
    repeat (3) @(negedge clk);
    chk("mid_we_low", we_n, 1'b0);
    #1 rst = 1'b0; probe_en = 1'b1;
    #1;
    chk("mid_rst_strobes", {ce_n, we_n}, 2'b11);
    chk("mid_rst_dq_hiz", sram_dq, 16'h5A5A);
    chk("mid_rst_ready_req", ready, 1'b0);
    wr_en = 1'b0; probe_en = 1'b0;
    #1;
    chk("mid_rst_ready_idle", ready, 1'b1);
    chk("mid_rst_rdata", rdata, 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    do_access(1'b0, 1'b1, 32'd1032, 32'h0, 4'hF, 1'b0, "rd_after_rst");

`ifdef SRAM_CTRL_BYTE_EN
    c0 = we_cnt[0];
    do_access(1'b1, 1'b0, 32'd1024, 32'h00AA0000, 4'b0100, 1'b0, "be_wr");
    chk("be_beat0_no_we", we_cnt[0], c0);
    chk("be_hi_const", mem[1], 16'hDEAA);
    chk("be_lo_const", mem[0], 16'hBEEF);
`else
    c0 = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + c0 - c0);
    $finish;
  end

endmodule
